// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (main M + skid K).
// Optional CSR-immediate (Z format) decode enabled by defining IMMGEN_ZICSR_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_Z    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [31:0]     imm32;
  fmt_e            fmt_d;
  logic [XLEN-1:0] imm_ext;
  entry_t          in_entry;
  entry_t          m_q, k_q;
  logic            m_valid, k_valid;
  logic            accept, m_free;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fmt_d = FMT_NONE;
    imm32 = '0;
    case (in_instr[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR: begin
        fmt_d = FMT_I;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
        if (in_instr[14]) begin
          fmt_d = FMT_Z;
          imm32 = {27'b0, in_instr[19:15]};
        end else begin
          fmt_d = FMT_I;
          imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
`else
        fmt_d = FMT_I;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
      end
      OP_STORE: begin
        fmt_d = FMT_S;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        fmt_d = FMT_B;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_d = FMT_U;
        imm32 = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt_d = FMT_J;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      default: begin
        fmt_d = FMT_NONE;
        imm32 = '0;
      end
    endcase
  end

  // Z immediates have bit 31 clear, so sign extension doubles as zero extension.
  generate
    if (XLEN > 32) begin : g_wide
      assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm_ext = imm32;
    end
  endgenerate

  assign in_entry = '{imm: imm_ext, fmt: fmt_d, instr: in_instr, tag: in_tag};

  assign in_ready = !k_valid;
  assign accept   = in_valid && in_ready;
  assign m_free   = !m_valid || out_ready;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: payload registers are reset too, because the outputs must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (m_free) begin
      if (k_valid) begin
        m_q     <= k_q;
        m_valid <= 1'b1;
        k_valid <= accept;
        if (accept) k_q <= in_entry;
      end else begin
        m_valid <= accept;
        if (accept) m_q <= in_entry;
      end
    end else if (accept) begin
      k_q     <= in_entry;
      k_valid <= 1'b1;
    end
  end

  assign out_valid = m_valid;
  assign out_imm   = m_q.imm;
  assign out_fmt   = m_q.fmt;
  assign out_instr = m_q.instr;
  assign out_tag   = m_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vectors, backpressure, flush,
// async reset, and a randomized stream scored against an arithmetic model.
module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [31:0]      out_instr;
  logic [TAG_W-1:0] out_tag;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t sb[$];

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_instr(out_instr), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Reference: immediate value as a plain integer from the field weights.
  task automatic ref_imm(input logic [31:0] ins, output logic [2:0] fmt,
                         output logic [XLEN-1:0] imm);
    longint v;
    longint s;
    v   = 0;
    s   = longint'(ins[31]);
    fmt = 3'd7;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin fmt = 3'd0; v = longint'(ins[31:20]) - s * 4096; end
      7'h73: begin
`ifdef IMMGEN_ZICSR_EN
        if (ins[14]) begin fmt = 3'd5; v = longint'(ins[19:15]); end
        else begin fmt = 3'd0; v = longint'(ins[31:20]) - s * 4096; end
`else
        fmt = 3'd0; v = longint'(ins[31:20]) - s * 4096;
`endif
      end
      7'h23: begin
        fmt = 3'd1;
        v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - s * 2048;
      end
      7'h63: begin
        fmt = 3'd2;
        v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
            - s * 4096;
      end
      7'h37, 7'h17: begin
        fmt = 3'd3;
        v = longint'(ins[30:12]) * 4096 - s * 64'h8000_0000;
      end
      7'h6F: begin
        fmt = 3'd4;
        v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
            + longint'(ins[30:21]) * 2 - s * 64'h10_0000;
      end
      default: begin fmt = 3'd7; v = 0; end
    endcase
    imm = XLEN'(v);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
    r = $urandom();
    if ($urandom_range(0, 9) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] c);
    return XLEN'(longint'($signed(c)));
  endfunction

  // One scoreboarded cycle, entered and left at a falling edge.
  task automatic sb_cycle(input bit v, input logic [31:0] ins, input logic [TAG_W-1:0] tg,
                          input bit ordy, input bit fl);
    logic [2:0]      ef;
    logic [XLEN-1:0] ei;
    exp_t            e;
    in_valid = v; in_instr = ins; in_tag = tg; out_ready = ordy && !fl; flush = fl;
    #1;
    if (out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got tag=%h, required no output", out_tag);
      end else begin
        e = sb.pop_front();
        ref_imm(e.instr, ef, ei);
        if (out_imm !== ei || out_fmt !== ef || out_instr !== e.instr || out_tag !== e.tag) begin
          errors++;
          $display("FAIL sb_entry: got imm=%h fmt=%0d instr=%h tag=%h, required imm=%h fmt=%0d instr=%h tag=%h",
                   out_imm, out_fmt, out_instr, out_tag, ei, ef, e.instr, e.tag);
        end
      end
    end
    if (fl) sb.delete();
    else if (v && in_ready) sb.push_back('{instr: ins, tag: tg});
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 20) begin
      sb_cycle(1'b0, 32'h0, '0, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_instr = '0; in_tag = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_imm !== '0 || out_fmt !== 3'd0 || out_instr !== '0 ||
        out_tag !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b imm=%h fmt=%0d instr=%h tag=%h rdy=%b, required all 0, rdy=1",
               out_valid, out_imm, out_fmt, out_instr, out_tag, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_formats();
    logic [31:0]     vi [7];
    logic [XLEN-1:0] ve [7];
    logic [2:0]      vf [7];
    vi = '{32'hFFF00093, 32'hFE112E23, 32'h000000E3, 32'h123452B7, 32'h0010006F,
           32'h00000000, 32'h0002D073};
    ve = '{sext32(32'hFFFFFFFF), sext32(32'hFFFFFFFC), sext32(32'h00000800),
           sext32(32'h12345000), sext32(32'h00000800), '0, '0};
    vf = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd0};
`ifdef IMMGEN_ZICSR_EN
    ve[6] = XLEN'(5);
    vf[6] = 3'd5;
`endif
    for (int k = 0; k <= 7; k++) begin
      out_ready = 1'b1;
      in_valid  = (k < 7);
      in_instr  = (k < 7) ? vi[k] : 32'h0;
      in_tag    = TAG_W'(k);
      #1;
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_fmt !== vf[k-1] || out_imm !== ve[k-1] ||
            out_instr !== vi[k-1]) begin
          errors++;
          $display("FAIL format_%0d: got v=%b fmt=%0d imm=%h instr=%h, required v=1 fmt=%0d imm=%h instr=%h",
                   k-1, out_valid, out_fmt, out_imm, out_instr, vf[k-1], ve[k-1], vi[k-1]);
        end
      end
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic bp_expect(input string nm, input bit ev, input logic [TAG_W-1:0] et,
                           input bit erdy);
    checks++;
    if (out_valid !== ev || (ev && out_tag !== et) || in_ready !== erdy) begin
      errors++;
      $display("FAIL %s: got v=%b tag=%h rdy=%b, required v=%b tag=%h rdy=%b",
               nm, out_valid, out_tag, in_ready, ev, et, erdy);
    end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] held_imm;
    in_instr = 32'h00500113;
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 1; #1;
    bp_expect("bp_c0", 1'b0, 0, 1'b1);
    @(negedge clk);
    in_tag = 2; #1;
    bp_expect("bp_c1", 1'b1, 1, 1'b1);
    held_imm = out_imm;
    @(negedge clk);
    in_tag = 3; #1;
    bp_expect("bp_c2_stall", 1'b1, 1, 1'b0);
    @(negedge clk);
    #1;
    bp_expect("bp_c3_hold", 1'b1, 1, 1'b0);
    checks++;
    if (out_imm !== held_imm) begin
      errors++;
      $display("FAIL bp_imm_hold: got %h, required %h", out_imm, held_imm);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    bp_expect("bp_c4_recover", 1'b1, 2, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; #1;
    bp_expect("bp_c5_tag3", 1'b1, 3, 1'b1);
    @(negedge clk);
    #1;
    bp_expect("bp_c6_empty", 1'b0, 0, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_flush();
    // M and K full, flush together with an offered input
    in_instr = 32'h00100093; out_ready = 1'b0; in_valid = 1'b1; in_tag = 10;
    @(negedge clk);
    in_tag = 11;
    @(negedge clk);
    in_tag = 12; flush = 1'b1; #1;
    bp_expect("flush_full_pre", 1'b1, 10, 1'b0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    bp_expect("flush_full_post", 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      bp_expect("flush_full_ghost", 1'b0, 0, 1'b1);
    end
    // M full, K empty: flush must win over an accepted input
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 20;
    @(negedge clk);
    in_tag = 21; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    bp_expect("flush_accept_post", 1'b0, 0, 1'b1);
    @(negedge clk); #1;
    bp_expect("flush_accept_ghost", 1'b0, 0, 1'b1);
    in_valid = 1'b1; in_tag = 22;
    @(negedge clk);
    in_valid = 1'b0; #1;
    bp_expect("flush_resume", 1'b1, 22, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_random_stream(input int n, input int tag_base);
    bit v, r, f;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 39) == 0);
      sb_cycle(v, rand_instr(), TAG_W'(tag_base + i), r, f);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) sb_cycle(1'b1, rand_instr(), TAG_W'(500 + i), 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_async_reset();
    sb_cycle(1'b1, 32'hFFF00093, 30, 1'b0, 1'b0);
    sb_cycle(1'b1, 32'h123452B7, 31, 1'b0, 1'b0);
    idle(); out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_imm !== '0 || out_fmt !== 3'd0 || out_instr !== '0 ||
        out_tag !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got v=%b imm=%h fmt=%0d instr=%h tag=%h rdy=%b, required all 0, rdy=1",
               out_valid, out_imm, out_fmt, out_instr, out_tag, in_ready);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_random_stream(60, 2000);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_formats();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random_stream(400, 1000);
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
